// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types for the core bus fabric.
// Bundles are indexed by master inside the arbiter.
package wb_pkg;

  localparam int WB_ADR_W = 28;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = WB_DAT_W / 8;

  localparam int WB_ARB_TIMEOUT_DEFAULT = 255;

  typedef logic [WB_ADR_W-1:0] adr_t;
  typedef logic [WB_DAT_W-1:0] dat_t;
  typedef logic [WB_SEL_W-1:0] sel_t;

  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
    adr_t adr;
    dat_t dat;
    sel_t sel;
  } wb_m2s_t;

  typedef struct packed {
    logic stall;
    logic ack;
    logic err;
    dat_t dat;
  } wb_s2m_t;

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational 2-way round-robin picker.
// On a tie the master that was not granted last wins.
module wb_rr_pick2
  import wb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       vld_o
);

  always_comb begin
    gnt_o = 1'b0;
    vld_o = |req_i;
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 pipelined arbiter, grant locked while CYC is high.
// Optional watchdog: define WB_ARBITER2_TIMEOUT_EN.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int ADR_W          = 28,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_o,
  input  logic [DAT_W/8-1:0] m0_sel,
  output logic               m0_stall,
  output logic               m0_ack,
  output logic               m0_err,
  output logic [DAT_W-1:0]   m0_dat_i,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_o,
  input  logic [DAT_W/8-1:0] m1_sel,
  output logic               m1_stall,
  output logic               m1_ack,
  output logic               m1_err,
  output logic [DAT_W-1:0]   m1_dat_i,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic [DAT_W/8-1:0] s_sel,
  input  logic               s_stall,
  input  logic               s_ack,
  input  logic               s_err,
  input  logic [DAT_W-1:0]   s_dat_i
);

  localparam wb_s2m_t RSP_IDLE = '{stall: 1'b1, ack: 1'b0,
                                   err: 1'b0, dat: '0};

  wb_m2s_t m_req [2];
  wb_s2m_t m_rsp [2];
  wb_m2s_t s_req;
  wb_s2m_t s_rsp;

  logic owner_vld_q, owner_vld_d;
  logic owner_q, owner_d;
  logic last_q, last_d;

  logic pick_gnt, pick_vld;
  logic locked, own_vld, own, act, new_grant, to;

  assign m_req[0] = '{cyc: m0_cyc, stb: m0_stb, we: m0_we,
                      adr: m0_adr, dat: m0_dat_o, sel: m0_sel};
  assign m_req[1] = '{cyc: m1_cyc, stb: m1_stb, we: m1_we,
                      adr: m1_adr, dat: m1_dat_o, sel: m1_sel};
  assign s_rsp    = '{stall: s_stall, ack: s_ack,
                      err: s_err, dat: s_dat_i};

  wb_rr_pick2 u_pick (
    .req_i  ({m1_cyc, m0_cyc}),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  assign locked    = owner_vld_q & m_req[owner_q].cyc;
  assign own_vld   = locked | pick_vld;
  assign own       = locked ? owner_q : pick_gnt;
  assign new_grant = own_vld & ~locked;
  assign act       = own_vld & ~rst & ~to;

`ifdef WB_ARBITER2_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts grant cycles already elapsed; fires on the Nth
  assign to = locked &
              (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!own_vld || to || s_ack || s_err) begin
      cnt_d = '0;
    end else if (new_grant) begin
      cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to = 1'b0;
`endif

  always_comb begin
    s_req    = '0;
    m_rsp[0] = RSP_IDLE;
    m_rsp[1] = RSP_IDLE;
    if (act) begin
      s_req      = m_req[own];
      m_rsp[own] = s_rsp;
    end
    if (to && !rst) begin
      m_rsp[own].err = 1'b1;
    end
  end

  always_comb begin
    owner_vld_d = own_vld & ~to;
    owner_d     = own_vld ? own : owner_q;
    last_d      = (new_grant || to) ? own : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign s_cyc    = s_req.cyc;
  assign s_stb    = s_req.stb;
  assign s_we     = s_req.we;
  assign s_adr    = s_req.adr;
  assign s_dat_o  = s_req.dat;
  assign s_sel    = s_req.sel;

  assign m0_stall = m_rsp[0].stall;
  assign m0_ack   = m_rsp[0].ack;
  assign m0_err   = m_rsp[0].err;
  assign m0_dat_i = m_rsp[0].dat;
  assign m1_stall = m_rsp[1].stall;
  assign m1_ack   = m_rsp[1].ack;
  assign m1_err   = m_rsp[1].err;
  assign m1_dat_i = m_rsp[1].dat;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: vector table plus corner sequences.
// Timeout sequence runs only when WB_ARBITER2_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [27:0] m0_adr;
  logic [31:0] m0_dat_o;
  logic [3:0]  m0_sel;
  logic        m0_stall, m0_ack, m0_err;
  logic [31:0] m0_dat_i;
  logic        m1_cyc, m1_stb, m1_we;
  logic [27:0] m1_adr;
  logic [31:0] m1_dat_o;
  logic [3:0]  m1_sel;
  logic        m1_stall, m1_ack, m1_err;
  logic [31:0] m1_dat_i;
  logic        s_cyc, s_stb, s_we;
  logic [27:0] s_adr;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_dat_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .ADR_W          (28),
    .DAT_W          (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_adr   (m0_adr),
    .m0_dat_o (m0_dat_o),
    .m0_sel   (m0_sel),
    .m0_stall (m0_stall),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_dat_i (m0_dat_i),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_adr   (m1_adr),
    .m1_dat_o (m1_dat_o),
    .m1_sel   (m1_sel),
    .m1_stall (m1_stall),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_dat_i (m1_dat_i),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel    (s_sel),
    .s_stall  (s_stall),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .s_dat_i  (s_dat_i)
  );

  typedef struct {
    logic        c0, s0, c1, s1, ack, stall;
    logic [31:0] sdat;
    logic        e_cyc;
    logic [27:0] e_adr;
    logic        e_st0, e_st1, e_ack0, e_ack1;
    logic [31:0] e_dat0;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_cyc = 0; m0_stb = 0;
    m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_stall = 0; s_err = 0; s_dat_i = 0;
  endtask

  int acks;

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,32'h0,        0,28'h0, 1,1,0,0,32'h0};
    tbl[1]  = '{0,0,0,0,1,0,32'hDEADBEEF, 0,28'h0, 1,1,0,0,32'h0};
    tbl[2]  = '{1,1,1,1,0,0,32'h0,        1,28'h10,0,1,0,0,32'h0};
    tbl[3]  = '{1,0,1,1,1,0,32'hDEADBEEF, 1,28'h10,0,1,1,0,32'hDEADBEEF};
    tbl[4]  = '{0,0,1,1,0,0,32'h0,        1,28'h20,1,0,0,0,32'h0};
    tbl[5]  = '{0,0,1,0,1,0,32'hCAFEF00D, 1,28'h20,1,0,0,1,32'h0};
    tbl[6]  = '{0,0,0,0,0,0,32'h0,        0,28'h0, 1,1,0,0,32'h0};
    tbl[7]  = '{1,1,1,1,0,0,32'h0,        1,28'h10,0,1,0,0,32'h0};
    tbl[8]  = '{1,1,1,1,0,1,32'h0,        1,28'h10,1,1,0,0,32'h0};
    tbl[9]  = '{0,0,0,0,0,0,32'h0,        0,28'h0, 1,1,0,0,32'h0};
    tbl[10] = '{1,1,1,1,0,0,32'h0,        1,28'h20,1,0,0,0,32'h0};
    tbl[11] = '{0,0,0,0,0,0,32'h0,        0,28'h0, 1,1,0,0,32'h0};

    m0_we = 0; m0_adr = 28'h10; m0_dat_o = 32'h11111111; m0_sel = 4'hF;
    m1_we = 1; m1_adr = 28'h20; m1_dat_o = 32'h0000A5A5; m1_sel = 4'h3;
    idle();
    rst = 1;
    m0_cyc = 1; m0_stb = 1;
    tick();
    #3;
    chk("reset s_cyc", s_cyc, 0);
    chk("reset m0_stall", m0_stall, 1);
    chk("reset m1_stall", m1_stall, 1);
    tick();
    rst = 0;
    idle();

    foreach (tbl[i]) begin
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
      s_ack = tbl[i].ack; s_stall = tbl[i].stall;
      s_dat_i = tbl[i].sdat;
      #3;
      chk($sformatf("row%0d s_cyc", i), s_cyc, tbl[i].e_cyc);
      chk($sformatf("row%0d s_adr", i), s_adr, tbl[i].e_adr);
      chk($sformatf("row%0d m0_stall", i), m0_stall, tbl[i].e_st0);
      chk($sformatf("row%0d m1_stall", i), m1_stall, tbl[i].e_st1);
      chk($sformatf("row%0d m0_ack", i), m0_ack, tbl[i].e_ack0);
      chk($sformatf("row%0d m1_ack", i), m1_ack, tbl[i].e_ack1);
      chk($sformatf("row%0d m0_dat_i", i), m0_dat_i, tbl[i].e_dat0);
      tick();
    end

    // M1 write held through three slave stall cycles
    idle();
    m1_cyc = 1; m1_stb = 1;
    s_stall = 1;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("wr%0d s_stb", k), s_stb, 1);
      chk($sformatf("wr%0d s_adr", k), s_adr, 28'h20);
      chk($sformatf("wr%0d s_sel", k), s_sel, 4'h3);
      chk($sformatf("wr%0d s_we", k), s_we, 1);
      chk($sformatf("wr%0d s_dat_o", k), s_dat_o, 32'h0000A5A5);
      chk($sformatf("wr%0d m1_stall", k), m1_stall, 1);
      acks += int'(m1_ack);
      tick();
    end
    s_stall = 0;
    #3;
    chk("wr accept m1_stall", m1_stall, 0);
    acks += int'(m1_ack);
    tick();
    m1_stb = 0; s_ack = 1;
    #3;
    acks += int'(m1_ack);
    tick();
    s_ack = 0;
    #3;
    acks += int'(m1_ack);
    chk("wr ack count", acks, 1);
    tick();
    idle();
    tick();

    // M0 single read, slave acks two cycles later
    m0_cyc = 1; m0_stb = 1;
    #3;
    chk("rd s_stb", s_stb, 1);
    chk("rd s_adr", s_adr, 28'h10);
    chk("rd m0_stall", m0_stall, 0);
    tick();
    m0_stb = 0;
    #3;
    chk("rd early ack", m0_ack, 0);
    tick();
    s_ack = 1; s_dat_i = 32'hDEADBEEF;
    #3;
    chk("rd m0_ack", m0_ack, 1);
    chk("rd m0_dat_i", m0_dat_i, 32'hDEADBEEF);
    chk("rd m1_ack", m1_ack, 0);
    tick();
    idle();
    tick();

    // Reset pulsed mid-transfer
    m0_cyc = 1; m0_stb = 1;
    tick();
    rst = 1; s_ack = 1;
    #3;
    chk("rst s_cyc", s_cyc, 0);
    chk("rst s_stb", s_stb, 0);
    chk("rst m0_stall", m0_stall, 1);
    chk("rst m1_stall", m1_stall, 1);
    chk("rst m0_ack", m0_ack, 0);
    chk("rst m1_ack", m1_ack, 0);
    tick();
    rst = 0; s_ack = 0;
    m1_cyc = 1; m1_stb = 1;
    #3;
    chk("post-rst tie s_adr", s_adr, 28'h10);
    chk("post-rst tie m1_stall", m1_stall, 1);
    tick();
    idle();
    tick();

`ifdef WB_ARBITER2_TIMEOUT_EN
    // Slave never answers; watchdog fires on the 8th grant cycle
    m0_cyc = 1; m0_stb = 1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        m1_cyc = 1; m1_stb = 1;
      end
      #3;
      chk($sformatf("to%0d m0_err", k), m0_err, (k == 8) ? 1 : 0);
      chk($sformatf("to%0d s_cyc", k), s_cyc, (k == 8) ? 0 : 1);
      tick();
    end
    m0_cyc = 0; m0_stb = 0;
    #3;
    chk("to m1 s_cyc", s_cyc, 1);
    chk("to m1 s_adr", s_adr, 28'h20);
    chk("to m1_stall", m1_stall, 0);
    tick();
    idle();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
